// File: rtl/bika_layer_ctrl_if.sv
// Signal bundle between the BiKA layer sequencer and its buffers, neuron lanes and result sink.
// master = sequencer side, slave = surrounding environment.
interface bika_layer_ctrl_if #(
  parameter int NUM_LANES = 4,
  parameter int ACT_AW    = 10,
  parameter int THR_AW    = 14
);
  logic                     start;
  logic [15:0]              cfg_in_length;
  logic [15:0]              cfg_num_out;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;
  logic                     act_rd_en;
  logic [ACT_AW-1:0]        act_addr;
  logic [7:0]               act_rdata;
  logic                     thr_rd_en;
  logic [THR_AW-1:0]        thr_addr;
  logic [NUM_LANES*8-1:0]   thr_rdata;
  logic [7:0]               nrn_activ;
  logic [NUM_LANES*8-1:0]   nrn_thr;
  logic                     nrn_in_valid;
  logic [15:0]              nrn_in_length;
  logic [NUM_LANES*16-1:0]  nrn_out;
  logic [NUM_LANES-1:0]     nrn_out_valid;
  logic [15:0]              res_data;
  logic [15:0]              res_idx;
  logic                     res_valid;
  logic                     res_ready;

  modport master (
    input  start, cfg_in_length, cfg_num_out, act_rdata, thr_rdata,
           nrn_out, nrn_out_valid, res_ready,
    output busy, done, cfg_err, act_rd_en, act_addr, thr_rd_en, thr_addr,
           nrn_activ, nrn_thr, nrn_in_valid, nrn_in_length,
           res_data, res_idx, res_valid
  );

  modport slave (
    output start, cfg_in_length, cfg_num_out, act_rdata, thr_rdata,
           nrn_out, nrn_out_valid, res_ready,
    input  busy, done, cfg_err, act_rd_en, act_addr, thr_rd_en, thr_addr,
           nrn_activ, nrn_thr, nrn_in_valid, nrn_in_length,
           res_data, res_idx, res_valid
  );
endinterface

// File: rtl/bika_layer_ctrl.sv
// Sequencer for one fully-connected BiKA layer: streams activations/thresholds into
// NUM_LANES neuron lanes group by group and serialises the lane sums as a result stream.
module bika_layer_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int ACT_AW    = 10,
  parameter int THR_AW    = 14
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  bika_layer_ctrl_if.master bus
);

  localparam int          SHIFT     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
  localparam int          LW        = (NUM_LANES > 1) ? SHIFT : 1;
  localparam logic [15:0] LANE_MASK = 16'(NUM_LANES - 1);

  typedef enum logic [2:0] {IDLE, CHECK, FEED, WAIT, DRAIN, FIN} state_t;

  state_t                  state, state_n;
  logic [15:0]             len_q;
  logic [15:0]             num_q;
  logic [15:0]             grp;
  logic [15:0]             elem;
  logic [THR_AW-1:0]       thr_base;
  logic [LW-1:0]           lane;
  logic [NUM_LANES*16-1:0] bank;
  logic                    err_q;
  logic                    in_valid_q;

  logic [15:0] num_groups;
  logic [15:0] grp_base;
  logic [15:0] remaining;
  logic [15:0] last_lane;
  logic [15:0] lane_ext;
  logic        last_group;
  logic        lane_done;
  logic        elem_last;
  logic        cfg_bad;
  logic        xfer;

  // Group count is ceil(num_out / NUM_LANES); the last group may be only partly populated.
  assign num_groups = (num_q >> SHIFT) + {15'd0, |(num_q & LANE_MASK)};
  assign grp_base   = grp << SHIFT;
  assign remaining  = num_q - grp_base;
  assign last_group = (grp == num_groups - 16'd1);
  assign last_lane  = last_group ? (remaining - 16'd1) : LANE_MASK;
  assign lane_ext   = 16'(lane);
  assign lane_done  = (lane_ext == last_lane);
  assign elem_last  = (elem == len_q - 16'd1);
  assign cfg_bad    = (len_q == 16'd0) || (num_q == 16'd0);
  assign xfer       = (state == DRAIN) && bus.res_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.act_rd_en = 1'b0;
    bus.act_addr  = '0;
    bus.thr_rd_en = 1'b0;
    bus.thr_addr  = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.res_idx   = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = CHECK;
      end
      CHECK: begin
        bus.busy = 1'b1;
        state_n  = cfg_bad ? FIN : FEED;
      end
      FEED: begin
        bus.busy      = 1'b1;
        bus.act_rd_en = 1'b1;
        bus.thr_rd_en = 1'b1;
        bus.act_addr  = ACT_AW'(elem);
        bus.thr_addr  = thr_base + THR_AW'(elem);
        if (elem_last) state_n = WAIT;
      end
      WAIT: begin
        bus.busy = 1'b1;
        if (bus.nrn_out_valid[0]) state_n = DRAIN;
      end
      DRAIN: begin
        bus.busy      = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data  = bank[int'(lane)*16 +: 16];
        bus.res_idx   = grp_base + lane_ext;
        if (xfer && lane_done) state_n = last_group ? FIN : FEED;
      end
      FIN: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters, holding bank and latched config; thr_base tracks g*in_length modulo the address width.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      len_q      <= '0;
      num_q      <= '0;
      grp        <= '0;
      elem       <= '0;
      thr_base   <= '0;
      lane       <= '0;
      bank       <= '0;
      err_q      <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= (state == FEED);
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q <= bus.cfg_in_length;
            num_q <= bus.cfg_num_out;
            err_q <= 1'b0;
          end
        end
        CHECK: begin
          grp      <= '0;
          elem     <= '0;
          thr_base <= '0;
          lane     <= '0;
          if (cfg_bad) err_q <= 1'b1;
        end
        FEED: begin
          elem <= elem_last ? 16'd0 : elem + 16'd1;
        end
        WAIT: begin
          lane <= '0;
          if (bus.nrn_out_valid[0]) bank <= bus.nrn_out;
        end
        DRAIN: begin
          if (xfer) begin
            if (lane_done) begin
              lane <= '0;
              if (!last_group) begin
                grp      <= grp + 16'd1;
                thr_base <= thr_base + THR_AW'(len_q);
              end
            end else begin
              lane <= lane + LW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RAM data already has its one-cycle latency, so it is presented alongside the delayed strobe.
  assign bus.nrn_in_valid  = in_valid_q;
  assign bus.nrn_activ     = in_valid_q ? bus.act_rdata : 8'd0;
  assign bus.nrn_thr       = in_valid_q ? bus.thr_rdata : '0;
  assign bus.nrn_in_length = len_q;
  assign bus.cfg_err       = err_q;

endmodule

// File: tb/tb_bika_layer_ctrl.sv
// Self-checking bench for bika_layer_ctrl: RAM and lane models, a read/result scoreboard,
// a table of layer configurations and hand sequences for stall, ignored start and reset.
module tb_bika_layer_ctrl;

  localparam int NL     = 4;
  localparam int ACT_AW = 10;
  localparam int THR_AW = 14;

  typedef struct {
    int         len;
    int         num;
    bit         rnd;
    bit         rready;
    logic [7:0] act;
    logic [31:0] thr;
    bit         err;
  } vec_t;

  typedef struct { logic [ACT_AW-1:0] act; logic [THR_AW-1:0] thr; } rd_t;
  typedef struct { logic [15:0] idx; logic [15:0] data; } res_t;

  logic sys_clk;
  logic sys_rst_n;

  bika_layer_ctrl_if #(.NUM_LANES(NL), .ACT_AW(ACT_AW), .THR_AW(THR_AW)) bus ();

  bika_layer_ctrl #(.NUM_LANES(NL), .ACT_AW(ACT_AW), .THR_AW(THR_AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int   checks = 0;
  int   errors = 0;
  bit   force_low = 0;
  bit   rand_ready = 0;
  int   exp_groups = 0;
  int   exp_len = 0;
  int   run_len = 0;
  rd_t  rd_q[$];
  res_t res_q[$];
  int   runs_q[$];
  vec_t vecs[7];

  logic signed [7:0] act_mem [1024];
  logic [31:0]       thr_mem [16384];

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) begin
    if (bus.act_rd_en) bus.act_rdata <= act_mem[bus.act_addr];
    if (bus.thr_rd_en) bus.thr_rdata <= thr_mem[bus.thr_addr];
  end

  // Lane model: +1 when activation >= threshold else -1, summed over in_length, gap drops the partial sum.
  logic p_valid;
  int   p   [NL];
  int   acc [NL];
  int   cnt;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p_valid           <= 1'b0;
      cnt               <= 0;
      bus.nrn_out_valid <= '0;
      bus.nrn_out       <= '0;
      for (int i = 0; i < NL; i++) begin
        acc[i] <= 0;
        p[i]   <= 0;
      end
    end else begin
      p_valid <= bus.nrn_in_valid;
      for (int i = 0; i < NL; i++)
        p[i] <= ($signed(bus.nrn_activ) >= $signed(bus.nrn_thr[8*i +: 8])) ? 1 : -1;
      bus.nrn_out_valid <= '0;
      if (p_valid) begin
        if (cnt + 1 == int'(bus.nrn_in_length)) begin
          cnt <= 0;
          for (int i = 0; i < NL; i++) begin
            acc[i] <= 0;
            bus.nrn_out[16*i +: 16] <= 16'(acc[i] + p[i]);
          end
          bus.nrn_out_valid <= '1;
        end else begin
          cnt <= cnt + 1;
          for (int i = 0; i < NL; i++) acc[i] <= acc[i] + p[i];
        end
      end else begin
        cnt <= 0;
        for (int i = 0; i < NL; i++) acc[i] <= 0;
      end
    end
  end

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      bus.res_ready = force_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every read and every presented result is matched against the expected queues.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      run_len = 0;
    end else begin
      if (bus.act_rd_en || bus.thr_rd_en) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_read: got act_addr %0h, expected no read at %0t", bus.act_addr, $time);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          checkOutput("act_addr", 64'(bus.act_addr), 64'(r.act));
          checkOutput("thr_addr", 64'(bus.thr_addr), 64'(r.thr));
          checkOutput("rd_en_pair", {62'd0, bus.act_rd_en, bus.thr_rd_en}, 64'd3);
        end
        checkOutput("feed_drain_overlap", 64'(bus.res_valid), 64'd0);
      end
      if (bus.res_valid) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_result: got idx %0d, expected none at %0t", bus.res_idx, $time);
        end else begin
          checkOutput("res_idx", 64'(bus.res_idx), 64'(res_q[0].idx));
          checkOutput("res_data", 64'(bus.res_data), 64'(res_q[0].data));
          if (bus.res_ready) void'(res_q.pop_front());
        end
      end
      if (bus.nrn_in_valid) begin
        run_len++;
      end else if (run_len > 0) begin
        runs_q.push_back(run_len);
        run_len = 0;
      end
    end
  end

  function automatic int model_sum(int g, int lane, int len);
    int s = 0;
    logic [31:0] w;
    logic signed [7:0] t;
    for (int k = 0; k < len; k++) begin
      w = thr_mem[g*len + k];
      t = w[8*lane +: 8];
      s += (act_mem[k] >= t) ? 1 : -1;
    end
    return s;
  endfunction

  task automatic load_mem(input int len, input int num, input bit rnd, input logic [7:0] act, input logic [31:0] thr);
    int groups = (num + NL - 1) / NL;
    for (int k = 0; k < len; k++) act_mem[k] = rnd ? 8'($urandom) : act;
    for (int i = 0; i < groups * len; i++) thr_mem[i] = rnd ? $urandom : thr;
  endtask

  task automatic queue_reads(input int len, input int num);
    int groups = (num + NL - 1) / NL;
    for (int g = 0; g < groups; g++)
      for (int k = 0; k < len; k++)
        rd_q.push_back('{act: ACT_AW'(k), thr: THR_AW'(g*len + k)});
    exp_groups = groups;
    exp_len    = len;
  endtask

  task automatic queue_result(input int idx, input int data);
    res_q.push_back('{idx: 16'(idx), data: 16'(data)});
  endtask

  task automatic queue_model_results(input int len, input int num);
    for (int n = 0; n < num; n++) queue_result(n, model_sum(n / NL, n % NL, len));
  endtask

  task automatic pulse_start(input int len, input int num);
    bus.start         = 1'b1;
    bus.cfg_in_length = 16'(len);
    bus.cfg_num_out   = 16'(num);
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rand_ready = v.rready;
    load_mem(v.len, v.num, v.rnd, v.act, v.thr);
    exp_groups = 0;
    exp_len    = v.len;
    if (!v.err) begin
      queue_reads(v.len, v.num);
      queue_model_results(v.len, v.num);
    end
    pulse_start(v.len, v.num);
  endtask

  task automatic wait_done(input bit exp_err, input string name);
    bit seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      checkOutput({name, "_cfg_err"}, 64'(bus.cfg_err), 64'(exp_err));
      checkOutput({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      checkOutput({name, "_results_left"}, 64'(res_q.size()), 64'd0);
      checkOutput({name, "_reads_left"}, 64'(rd_q.size()), 64'd0);
      checkOutput({name, "_feed_phases"}, 64'(runs_q.size()), 64'(exp_groups));
      foreach (runs_q[j]) checkOutput({name, "_feed_len"}, 64'(runs_q[j]), 64'(exp_len));
      @(negedge sys_clk);
      checkOutput({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    end
    runs_q.delete();
    rd_q.delete();
    res_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    checkOutput({name, "_ctrl"},
                64'({bus.busy, bus.done, bus.cfg_err, bus.act_rd_en, bus.thr_rd_en,
                     bus.nrn_in_valid, bus.res_valid}), 64'd0);
    checkOutput({name, "_addr"}, 64'({bus.act_addr, bus.thr_addr, bus.nrn_in_length}), 64'd0);
    checkOutput({name, "_nrn"}, 64'({bus.nrn_activ, bus.nrn_thr}), 64'd0);
    checkOutput({name, "_res"}, 64'({bus.res_data, bus.res_idx}), 64'd0);
  endtask

  task automatic run_case1();
    rand_ready = 0;
    load_mem(3, 4, 0, 8'd5, {8'h80, 8'd6, 8'd5, 8'd4});
    queue_reads(3, 4);
    queue_result(0, 3);
    queue_result(1, 3);
    queue_result(2, -3);
    queue_result(3, 3);
    pulse_start(3, 4);
  endtask

  initial begin
    bit found;
    vecs[0] = '{len: 2,  num: 6, rnd: 1, rready: 0, act: 8'd0, thr: 32'd0, err: 0};
    vecs[1] = '{len: 5,  num: 3, rnd: 1, rready: 1, act: 8'd0, thr: 32'd0, err: 0};
    vecs[2] = '{len: 1,  num: 1, rnd: 1, rready: 0, act: 8'd0, thr: 32'd0, err: 0};
    vecs[3] = '{len: 0,  num: 4, rnd: 0, rready: 0, act: 8'd0, thr: 32'd0, err: 1};
    vecs[4] = '{len: 4,  num: 0, rnd: 0, rready: 0, act: 8'd0, thr: 32'd0, err: 1};
    vecs[5] = '{len: 7,  num: 9, rnd: 1, rready: 1, act: 8'd0, thr: 32'd0, err: 0};
    vecs[6] = '{len: 16, num: 8, rnd: 1, rready: 0, act: 8'd0, thr: 32'd0, err: 0};

    bus.start         = 1'b0;
    bus.cfg_in_length = '0;
    bus.cfg_num_out   = '0;
    sys_rst_n         = 1'b1;
    #1 sys_rst_n      = 1'b0;
    @(negedge sys_clk);
    check_all_zero("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    $display("[TB] basic layer in_length=3 num_out=4");
    run_case1();
    wait_done(0, "case1");

    $display("[TB] table of layer configurations");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      wait_done(vecs[i].err, $sformatf("vec%0d", i));
    end
    rand_ready = 0;

    $display("[TB] zero in_length timing");
    exp_groups = 0;
    bus.start         = 1'b1;
    bus.cfg_in_length = 16'd0;
    bus.cfg_num_out   = 16'd4;
    @(negedge sys_clk);
    bus.start = 1'b0;
    checkOutput("zero_len_busy_c1", 64'(bus.busy), 64'd1);
    checkOutput("zero_len_done_c1", 64'(bus.done), 64'd0);
    checkOutput("zero_len_err_cleared", 64'(bus.cfg_err), 64'd0);
    @(negedge sys_clk);
    checkOutput("zero_len_done_c2", 64'(bus.done), 64'd1);
    checkOutput("zero_len_err_c2", 64'(bus.cfg_err), 64'd1);
    @(negedge sys_clk);
    checkOutput("zero_len_done_c3", 64'(bus.done), 64'd0);
    checkOutput("zero_len_busy_c3", 64'(bus.busy), 64'd0);
    checkOutput("zero_len_err_held", 64'(bus.cfg_err), 64'd1);
    checkOutput("zero_len_no_feed", 64'(runs_q.size()), 64'd0);

    $display("[TB] result stall mid-drain");
    applyStimulus('{len: 2, num: 6, rnd: 1, rready: 0, act: 8'd0, thr: 32'd0, err: 0});
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.res_valid && bus.res_idx == 16'd2) begin
        found = 1;
        break;
      end
      @(negedge sys_clk);
    end
    checkOutput("stall_reach_idx2", 64'(found), 64'd1);
    force_low = 1;
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid_held", 64'(bus.res_valid), 64'd1);
      checkOutput("stall_idx_held", 64'(bus.res_idx), 64'd3);
      checkOutput("stall_no_read", 64'(bus.act_rd_en), 64'd0);
      @(negedge sys_clk);
    end
    force_low = 0;
    wait_done(0, "stall");

    $display("[TB] start pulsed during feed");
    applyStimulus('{len: 8, num: 4, rnd: 1, rready: 0, act: 8'd0, thr: 32'd0, err: 0});
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.act_rd_en) begin
        found = 1;
        break;
      end
      @(negedge sys_clk);
    end
    checkOutput("ignore_reach_feed", 64'(found), 64'd1);
    pulse_start(1, 1);
    checkOutput("ignore_len_held", 64'(bus.nrn_in_length), 64'd8);
    checkOutput("ignore_busy", 64'(bus.busy), 64'd1);
    wait_done(0, "ignore");

    $display("[TB] reset during wait");
    run_case1();
    found = 0;
    begin
      bit seen_rd = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge sys_clk);
        if (bus.act_rd_en) seen_rd = 1;
        else if (seen_rd) begin
          found = 1;
          break;
        end
      end
    end
    checkOutput("reset_reach_wait", 64'(found), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge sys_clk);
    check_all_zero("midreset_hold");
    rd_q.delete();
    res_q.delete();
    runs_q.delete();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    run_case1();
    wait_done(0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bika_layer_ctrl.md
Name: bika_layer_ctrl

Overview:
Sequencer for one fully-connected BiKA layer built from NUM_LANES threshold-compare/accumulate neuron lanes. It computes the layer as groups of NUM_LANES output neurons.
- Activations and per-lane thresholds are read from external synchronous RAMs, then streamed contiguously into the lanes.
- Lane sums are captured and emitted as a serial valid/ready result stream.
- It sits between the layer buffers and the neuron array, and is started once per layer by the network-level controller.

Parameters:
NUM_LANES, 4, neuron lanes driven in parallel (power of 2, 1..16)
ACT_AW, 10, activation RAM address width
THR_AW, 14, threshold RAM address width (one word = NUM_LANES x 8 bit)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle layer start pulse
cfg_in_length  in  16  fan-in per neuron (activations per output)
cfg_num_out  in  16  output neurons in the layer
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
cfg_err  out  1  high with done when the config was rejected
act_rd_en  out  1  activation RAM read strobe
act_addr  out  ACT_AW  activation RAM address
act_rdata  in  8  signed activation, valid 1 cycle after act_rd_en
thr_rd_en  out  1  threshold RAM read strobe
thr_addr  out  THR_AW  threshold RAM address
thr_rdata  in  NUM_LANES*8  signed thresholds, lane i at [8i+7:8i], 1-cycle latency
nrn_activ  out  8  activation broadcast to all lanes
nrn_thr  out  NUM_LANES*8  per-lane thresholds
nrn_in_valid  out  1  lane input valid
nrn_in_length  out  16  fan-in to lanes (registered cfg_in_length)
nrn_out  in  NUM_LANES*16  signed lane sums
nrn_out_valid  in  NUM_LANES  lane sum valid strobes
res_data  out  16  signed neuron sum
res_idx  out  16  output neuron index
res_valid  out  1  result valid
res_ready  in  1  downstream ready

Behaviour:
- Reset: FSM IDLE. All outputs 0: busy, done, cfg_err, rd_ens, addresses, nrn_*, res_*. Group and element counters cleared. Lanes share sys_rst_n, so reset mid-layer aborts cleanly and no done is issued.
- FSM states: IDLE, CHECK, FEED, WAIT, DRAIN, FIN.
- IDLE: start latches cfg_in_length and cfg_num_out, sets busy, goes to CHECK. start while busy is ignored.
- CHECK: if in_length==0 or num_out==0, go to FIN with cfg_err=1 and issue no RAM reads. Otherwise set group g=0 and go to FEED.
- FEED: issue exactly in_length back-to-back reads, one per cycle, with no gaps. Lanes drop partial counts on a gap, so gaps are forbidden.
  - Element k: act_addr=k, thr_addr=g*in_length+k, both rd_en high.
  - One cycle later: nrn_activ=act_rdata, nrn_thr=thr_rdata, nrn_in_valid=1. These are registered from RAM data, i.e. nrn_in_valid is rd_en delayed by 1.
  - After the last read, go to WAIT.
- WAIT: on nrn_out_valid[0], capture all NUM_LANES nrn_out words into a holding bank and go to DRAIN. Lanes run in lockstep.
  - Expected arrival: 3 cycles after the last read cycle (RAM 1 + product 1 + sum 1).
- DRAIN: present lanes 0..L-1 in order, with res_idx=g*NUM_LANES+lane.
  - L = NUM_LANES, except in the last group, where L = num_out - g*NUM_LANES. Lanes beyond L are skipped.
  - Handshake: a transfer occurs when res_valid&&res_ready. res_data and res_idx stay stable while res_valid && !res_ready.
  - After the last transfer: if more groups remain, g++ and go to FEED the next cycle, with no FEED in parallel with DRAIN. Otherwise go to FIN.
- FIN: done=1 for one cycle, busy=0, back to IDLE. cfg_err holds its value until the next accepted start.
- Widths: thr_addr = low THR_AW bits of g*in_length+k (truncation is the caller's responsibility). act_addr = low ACT_AW bits of k.
- Groups: ceil(num_out/NUM_LANES), computed with shift and mask.
- Result format: res_data is the signed lane sum, in range -in_length..+in_length.

Test Plan:
- NUM_LANES=4, in_length=3, num_out=4, all activations 5, thresholds lane0..3 = {4,5,6,-128}:
  - Required: 3 contiguous nrn_in_valid cycles.
  - Required results idx0..3 = {3,3,-3,3}, then done with cfg_err=0.
- in_length=2, num_out=6:
  - Required: two FEED phases; thr_addr sequences 0,1 then 2,3.
  - Required: res_idx 0..5 only; lanes 2,3 of group 1 skipped; done after idx 5.
- res_ready low for 5 cycles mid-DRAIN:
  - Required: res_data and res_idx held; no results lost or duplicated; no FEED until DRAIN ends.
- start with in_length=0:
  - Required: no rd_en asserted; done and cfg_err=1 two cycles after start; busy low after.
- Second start pulsed during FEED: ignored, outputs unchanged.
- sys_rst_n asserted during WAIT:
  - Required: all outputs 0 immediately.
  - Required: a new start afterwards runs the in_length=3 case with correct sums.
